// File: rtl/mips_ex_control.sv
// Decodes instruction_F into the registered EX control word (1-cycle latency).
// Stalls fetch for one cycle per bne, interlocks HI/LO users behind a multi-cycle mult, decodes GPIO strobes.
module mips_ex_control #(
   parameter int MULT_CYCLES   = 4,
   parameter int GPIO_CHANNELS = 2,
   parameter int SHAMT_W       = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     instr_valid,
   input  logic [31:0]              instruction_F,
   input  logic                     zero_EX,
   output logic                     instr_ready,
   output logic                     valid_EX,
   output logic [3:0]               alu_op_EX,
   output logic [SHAMT_W-1:0]       shamt_EX,
   output logic [1:0]               regsel_EX,
   output logic                     enhilo_EX,
   output logic                     regwrite_EX,
   output logic [1:0]               alu_src_EX,
   output logic                     rdrt_EX,
   output logic [1:0]               pc_src_EX,
   output logic [GPIO_CHANNELS-1:0] gpio_out_en,
   output logic                     illegal_EX
);

   localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_NOR  = 4'b0010,
                          ALU_XOR = 4'b0011, ALU_ADD = 4'b0100, ALU_SUB  = 4'b0101,
                          ALU_MULT = 4'b0110, ALU_MULTU = 4'b0111, ALU_SLL = 4'b1000,
                          ALU_SRL = 4'b1001, ALU_SRA = 4'b1010, ALU_SLT  = 4'b1011,
                          ALU_SLTU = 4'b1100;
   localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

   typedef enum logic {S_RUN, S_BRANCH} state_t;

   state_t                   r_state, w_state_nxt;
   logic [CNT_W-1:0]         r_mult_cnt;
   logic                     r_valid, r_illegal, r_enhilo, r_regwrite, r_rdrt;
   logic [3:0]               r_alu_op;
   logic [SHAMT_W-1:0]       r_shamt;
   logic [1:0]               r_regsel, r_alu_src;
   logic [GPIO_CHANNELS-1:0] r_gpio;

   logic                     w_valid, w_illegal, w_enhilo, w_regwrite, w_rdrt;
   logic [3:0]               w_alu_op;
   logic [SHAMT_W-1:0]       w_shamt;
   logic [1:0]               w_regsel, w_alu_src, w_pc_src;
   logic [GPIO_CHANNELS-1:0] w_gpio;
   logic                     w_is_bne, w_is_mult, w_hilo_user, w_ready, w_accept;
   logic [5:0]               w_opcode, w_funct;
   logic [4:0]               w_rd, w_sh;

   assign w_opcode = instruction_F[31:26];
   assign w_funct  = instruction_F[5:0];
   assign w_rd     = instruction_F[15:11];
   assign w_sh     = instruction_F[10:6];

   assign w_hilo_user = (w_opcode == 6'h00) &&
                        (w_funct == 6'h10 || w_funct == 6'h12 || w_funct == 6'h18 || w_funct == 6'h19);

   always_comb begin
      w_valid    = 1'b1;
      w_illegal  = 1'b0;
      w_alu_op   = ALU_AND;
      w_shamt    = '0;
      w_regsel   = 2'd0;
      w_enhilo   = 1'b0;
      w_regwrite = 1'b0;
      w_alu_src  = 2'd0;
      w_rdrt     = 1'b0;
      w_gpio     = '0;
      w_is_bne   = 1'b0;
      w_is_mult  = 1'b0;
      if (instruction_F == 32'h0) begin
         w_valid = 1'b1;
      end else if (w_opcode == 6'h00 && w_funct == 6'h02 && w_sh == 5'd0) begin
         // srl by zero is repurposed as a GPIO write; rd selects the channel
         w_alu_op = ALU_SRL;
         for (int c = 0; c < GPIO_CHANNELS; c++) w_gpio[c] = (int'(w_rd) == c);
      end else if (w_opcode == 6'h00) begin
         w_regwrite = 1'b1;
         case (w_funct)
            6'h20, 6'h21: w_alu_op = ALU_ADD;
            6'h22, 6'h23: w_alu_op = ALU_SUB;
            6'h24:        w_alu_op = ALU_AND;
            6'h25:        w_alu_op = ALU_OR;
            6'h26:        w_alu_op = ALU_XOR;
            6'h27:        w_alu_op = ALU_NOR;
            6'h2A:        w_alu_op = ALU_SLT;
            6'h2B:        w_alu_op = ALU_SLTU;
            6'h00:        begin w_alu_op = ALU_SLL; w_shamt = SHAMT_W'(w_sh); end
            6'h02:        begin w_alu_op = ALU_SRL; w_shamt = SHAMT_W'(w_sh); end
            6'h03:        begin w_alu_op = ALU_SRA; w_shamt = SHAMT_W'(w_sh); end
            6'h18, 6'h19: begin
               w_alu_op   = w_funct[0] ? ALU_MULTU : ALU_MULT;
               w_enhilo   = 1'b1;
               w_regwrite = 1'b0;
               w_is_mult  = 1'b1;
            end
            6'h10:        w_regsel = 2'd1;
            6'h12:        w_regsel = 2'd2;
            default:      begin w_valid = 1'b0; w_illegal = 1'b1; w_regwrite = 1'b0; end
         endcase
      end else begin
         case (w_opcode)
            6'h08, 6'h09: begin w_alu_op = ALU_ADD; w_alu_src = 2'd1; w_rdrt = 1'b1; w_regwrite = 1'b1; end
            6'h0F: begin
               w_alu_op = ALU_SLL; w_shamt = SHAMT_W'(16);
               w_alu_src = 2'd1; w_rdrt = 1'b1; w_regwrite = 1'b1;
            end
            6'h0D:   begin w_alu_op = ALU_OR; w_alu_src = 2'd2; w_rdrt = 1'b1; w_regwrite = 1'b1; end
            6'h05:   begin w_alu_op = ALU_SUB; w_is_bne = 1'b1; end
            default: begin w_valid = 1'b0; w_illegal = 1'b1; end
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_pc_src    = 2'b00;
      case (r_state)
         S_RUN: begin
            w_ready = rst & ~((r_mult_cnt != '0) & w_hilo_user);
            if (instr_valid && w_ready && w_is_bne) w_state_nxt = S_BRANCH;
         end
         S_BRANCH: begin
            w_pc_src    = {1'b0, ~zero_EX};
            w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   assign w_accept = instr_valid & w_ready;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_RUN;
      else      r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst)                          r_mult_cnt <= '0;
      else if (w_accept && w_is_mult)    r_mult_cnt <= CNT_LOAD;
      else if (r_mult_cnt != '0)         r_mult_cnt <= r_mult_cnt - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst || !w_accept) begin
         r_valid <= 1'b0; r_illegal <= 1'b0; r_alu_op <= '0; r_shamt <= '0;
         r_regsel <= '0; r_enhilo <= 1'b0; r_regwrite <= 1'b0; r_alu_src <= '0;
         r_rdrt <= 1'b0; r_gpio <= '0;
      end else begin
         r_valid <= w_valid; r_illegal <= w_illegal; r_alu_op <= w_alu_op; r_shamt <= w_shamt;
         r_regsel <= w_regsel; r_enhilo <= w_enhilo; r_regwrite <= w_regwrite; r_alu_src <= w_alu_src;
         r_rdrt <= w_rdrt; r_gpio <= w_gpio;
      end
   end

   assign instr_ready = w_ready;
   assign pc_src_EX   = w_pc_src;
   assign valid_EX    = r_valid;
   assign illegal_EX  = r_illegal;
   assign alu_op_EX   = r_alu_op;
   assign shamt_EX    = r_shamt;
   assign regsel_EX   = r_regsel;
   assign enhilo_EX   = r_enhilo;
   assign regwrite_EX = r_regwrite;
   assign alu_src_EX  = r_alu_src;
   assign rdrt_EX     = r_rdrt;
   assign gpio_out_en = r_gpio;

endmodule

// File: tb/tb_mips_ex_control.sv
// Bench for mips_ex_control: fixed vectors, hand sequences for branch/multiply/reset, random run vs a cycle-count model.
module tb_mips_ex_control;
   localparam int MULT_CYCLES = 4, GPIO_CHANNELS = 2, SHAMT_W = 5;

   logic clk = 1'b0;
   logic rst, instr_valid, zero_EX;
   logic [31:0] instruction_F;
   logic instr_ready, valid_EX, enhilo_EX, regwrite_EX, rdrt_EX, illegal_EX;
   logic [3:0] alu_op_EX;
   logic [SHAMT_W-1:0] shamt_EX;
   logic [1:0] regsel_EX, alu_src_EX, pc_src_EX;
   logic [GPIO_CHANNELS-1:0] gpio_out_en;

   always #5 clk = ~clk;

   mips_ex_control #(.MULT_CYCLES(MULT_CYCLES), .GPIO_CHANNELS(GPIO_CHANNELS), .SHAMT_W(SHAMT_W)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction_F(instruction_F), .zero_EX(zero_EX),
      .instr_ready(instr_ready), .valid_EX(valid_EX), .alu_op_EX(alu_op_EX), .shamt_EX(shamt_EX),
      .regsel_EX(regsel_EX), .enhilo_EX(enhilo_EX), .regwrite_EX(regwrite_EX), .alu_src_EX(alu_src_EX),
      .rdrt_EX(rdrt_EX), .pc_src_EX(pc_src_EX), .gpio_out_en(gpio_out_en), .illegal_EX(illegal_EX));

   typedef struct packed {
      logic valid; logic illegal; logic [3:0] alu_op; logic [4:0] shamt; logic [1:0] regsel;
      logic enhilo; logic regwrite; logic [1:0] alu_src; logic rdrt; logic [1:0] gpio;
   } ex_t;
   typedef struct { logic [31:0] instr; ex_t exp; string name; } vec_t;

   localparam logic [31:0] I_ADD = 32'h00221820, I_BNE = 32'h14220004,
                           I_MULT = 32'h00220018, I_MFLO = 32'h00001812;

   int checks = 0, errors = 0;
   int nedges = 0, last_mult = -1000;
   bit br_pending = 1'b0;
   ex_t mex = '0;
   logic s_rdy;
   logic [1:0] s_pc;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic ex_t ex_word();
      ex_t e;
      e = {valid_EX, illegal_EX, alu_op_EX, shamt_EX, regsel_EX, enhilo_EX, regwrite_EX,
           alu_src_EX, rdrt_EX, gpio_out_en};
      return e;
   endfunction

   function automatic ex_t mk(input logic v, input logic il, input logic [3:0] op, input logic [4:0] sh,
                              input logic [1:0] rs, input logic eh, input logic rw, input logic [1:0] src,
                              input logic rt, input logic [1:0] g);
      ex_t e;
      e = {v, il, op, sh, rs, eh, rw, src, rt, g};
      return e;
   endfunction

   // Reference decode: instruction -> EX control word, straight from the instruction table.
   function automatic ex_t model_decode(input logic [31:0] i);
      ex_t e;
      logic [5:0] op, fn;
      op = i[31:26]; fn = i[5:0];
      e = '0; e.valid = 1'b1;
      if (i == 32'h0) return e;
      if (op == 6'h00) begin
         e.regwrite = 1'b1;
         case (fn)
            6'h20, 6'h21: e.alu_op = 4'd4;
            6'h22, 6'h23: e.alu_op = 4'd5;
            6'h24: e.alu_op = 4'd0;
            6'h25: e.alu_op = 4'd1;
            6'h27: e.alu_op = 4'd2;
            6'h26: e.alu_op = 4'd3;
            6'h2A: e.alu_op = 4'd11;
            6'h2B: e.alu_op = 4'd12;
            6'h00: begin e.alu_op = 4'd8;  e.shamt = i[10:6]; end
            6'h03: begin e.alu_op = 4'd10; e.shamt = i[10:6]; end
            6'h02: begin
               e.alu_op = 4'd9; e.shamt = i[10:6];
               if (i[10:6] == 5'd0) begin
                  e.regwrite = 1'b0;
                  if (int'(i[15:11]) < GPIO_CHANNELS) e.gpio = 2'(32'd1 << i[15:11]);
               end
            end
            6'h18, 6'h19: begin e.alu_op = fn[0] ? 4'd7 : 4'd6; e.enhilo = 1'b1; e.regwrite = 1'b0; end
            6'h10: e.regsel = 2'd1;
            6'h12: e.regsel = 2'd2;
            default: begin e = '0; e.illegal = 1'b1; end
         endcase
      end else begin
         case (op)
            6'h08, 6'h09: begin e.alu_op = 4'd4; e.alu_src = 2'd1; e.rdrt = 1'b1; e.regwrite = 1'b1; end
            6'h0F: begin e.alu_op = 4'd8; e.shamt = 5'd16; e.alu_src = 2'd1; e.rdrt = 1'b1; e.regwrite = 1'b1; end
            6'h0D: begin e.alu_op = 4'd1; e.alu_src = 2'd2; e.rdrt = 1'b1; e.regwrite = 1'b1; end
            6'h05: e.alu_op = 4'd5;
            default: begin e = '0; e.illegal = 1'b1; end
         endcase
      end
      return e;
   endfunction

   function automatic bit uses_hilo(input logic [31:0] i);
      return i[31:26] == 6'h00 && (i[5:0] == 6'h10 || i[5:0] == 6'h12 || i[5:0] == 6'h18 || i[5:0] == 6'h19);
   endfunction

   // One clock: drive inputs, check handshake at negedge against the model, advance model, check EX word.
   task automatic cycle(input logic rv, input logic vv, input logic [31:0] iv, input logic zv);
      bit stall, acc;
      logic exp_rdy;
      logic [1:0] exp_pc;
      rst = rv; instr_valid = vv; instruction_F = iv; zero_EX = zv;
      @(negedge clk);
      // HI/LO users may enter EX only MULT_CYCLES edges after the mult did
      stall   = uses_hilo(iv) && (nedges - last_mult < MULT_CYCLES);
      exp_rdy = rv && !br_pending && !stall;
      exp_pc  = br_pending ? {1'b0, ~zv} : 2'b00;
      s_rdy = instr_ready; s_pc = pc_src_EX;
      chk("instr_ready", 64'(s_rdy), 64'(exp_rdy));
      chk("pc_src", 64'(s_pc), 64'(exp_pc));
      acc = vv && exp_rdy;
      @(posedge clk);
      if (!rv) begin
         mex = '0; br_pending = 1'b0; last_mult = -1000;
      end else if (acc) begin
         mex = model_decode(iv);
         br_pending = (iv[31:26] == 6'h05);
         if (uses_hilo(iv) && iv[4:3] == 2'b11) last_mult = nedges;
      end else begin
         mex = '0; br_pending = 1'b0;
      end
      nedges++;
      #1;
      chk("ex_word", 64'(ex_word()), 64'(mex));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0] rs, rt, rd, sh;
      logic [15:0] imm;
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom); imm = 16'($urandom);
      case ($urandom_range(0, 15))
         0, 1: return {6'd0, rs, rt, rd, 5'd0, 6'h20 + 6'($urandom_range(0, 7))};
         2:    return {6'd0, rs, rt, rd, 5'd0, ($urandom_range(0, 1) != 0) ? 6'h2A : 6'h2B};
         3:    return {6'd0, 5'd0, rt, rd, sh, ($urandom_range(0, 1) != 0) ? 6'h00 : 6'h03};
         4:    return {6'd0, 5'd0, rt, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 1)), 6'h02};
         5, 6: return {6'd0, rs, rt, 10'd0, 5'h0C, 1'($urandom)};
         7, 8: return {16'd0, rd, 5'd0, ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12};
         9:    return {5'b00100, 1'($urandom), rs, rt, imm};
         10:   return {6'h0F, 5'd0, rt, imm};
         11:   return {6'h0D, rs, rt, imm};
         12:   return {6'h05, rs, rt, imm};
         13:   return 32'h0;
         14:   return {($urandom_range(0, 1) != 0) ? 6'h3F : 6'h23, rs, rt, imm};
         default: return {6'd0, rs, rt, rd, 5'd0, ($urandom_range(0, 1) != 0) ? 6'h08 : 6'h3F};
      endcase
   endfunction

   vec_t vecs[$];
   int   stalls, ncyc;

   initial begin
      vecs.push_back('{I_ADD,        mk(1,0,4'd4, 5'd0, 2'd0,0,1,2'd0,0,2'b00), "add"});
      vecs.push_back('{32'h3C051234, mk(1,0,4'd8, 5'd16,2'd0,0,1,2'd1,1,2'b00), "lui"});
      vecs.push_back('{32'h34A55678, mk(1,0,4'd1, 5'd0, 2'd0,0,1,2'd2,1,2'b00), "ori"});
      vecs.push_back('{32'h00221822, mk(1,0,4'd5, 5'd0, 2'd0,0,1,2'd0,0,2'b00), "sub"});
      vecs.push_back('{32'h00221827, mk(1,0,4'd2, 5'd0, 2'd0,0,1,2'd0,0,2'b00), "nor"});
      vecs.push_back('{32'h0022182B, mk(1,0,4'd12,5'd0, 2'd0,0,1,2'd0,0,2'b00), "sltu"});
      vecs.push_back('{32'h00021FC3, mk(1,0,4'd10,5'd31,2'd0,0,1,2'd0,0,2'b00), "sra31"});
      vecs.push_back('{32'h2022FFFF, mk(1,0,4'd4, 5'd0, 2'd0,0,1,2'd1,1,2'b00), "addi"});
      vecs.push_back('{32'h00020802, mk(1,0,4'd9, 5'd0, 2'd0,0,0,2'd0,0,2'b10), "gpio_ch1"});
      vecs.push_back('{32'h00020002, mk(1,0,4'd9, 5'd0, 2'd0,0,0,2'd0,0,2'b01), "gpio_ch0"});
      vecs.push_back('{32'h00022002, mk(1,0,4'd9, 5'd0, 2'd0,0,0,2'd0,0,2'b00), "gpio_out_of_range"});
      vecs.push_back('{32'h000208C2, mk(1,0,4'd9, 5'd3, 2'd0,0,1,2'd0,0,2'b00), "srl3"});
      vecs.push_back('{32'h00000000, mk(1,0,4'd0, 5'd0, 2'd0,0,0,2'd0,0,2'b00), "nop"});
      vecs.push_back('{32'h00001810, mk(1,0,4'd0, 5'd0, 2'd1,0,1,2'd0,0,2'b00), "mfhi"});
      vecs.push_back('{32'h00220019, mk(1,0,4'd7, 5'd0, 2'd0,1,0,2'd0,0,2'b00), "multu"});
      vecs.push_back('{I_BNE,        mk(1,0,4'd5, 5'd0, 2'd0,0,0,2'd0,0,2'b00), "bne"});
      vecs.push_back('{32'hFC000000, mk(0,1,4'd0, 5'd0, 2'd0,0,0,2'd0,0,2'b00), "illegal_op"});
      vecs.push_back('{32'h0022183F, mk(0,1,4'd0, 5'd0, 2'd0,0,0,2'd0,0,2'b00), "illegal_funct"});

      rst = 1'b0; instr_valid = 1'b1; instruction_F = I_ADD; zero_EX = 1'b0;
      repeat (2) begin
         cycle(1'b0, 1'b1, I_ADD, 1'b0);
         chk("reset_ex", 64'(ex_word()), 64'd0);
         chk("reset_rdy", 64'(s_rdy), 64'd0);
      end

      foreach (vecs[k]) begin
         cycle(1'b1, 1'b1, vecs[k].instr, 1'b0);
         chk(vecs[k].name, 64'(ex_word()), 64'(vecs[k].exp));
         repeat (MULT_CYCLES) cycle(1'b1, 1'b0, 32'h0, 1'b0);
      end

      for (int z = 0; z < 2; z++) begin
         cycle(1'b1, 1'b1, I_BNE, 1'b0);
         cycle(1'b1, 1'b1, I_ADD, 1'(z));
         chk("bne_stall", 64'(s_rdy), 64'd0);
         chk("bne_pc", 64'(s_pc), (z == 0) ? 64'd1 : 64'd0);
         chk("bne_bubble", 64'(valid_EX), 64'd0);
         cycle(1'b1, 1'b1, I_ADD, 1'b0);
         chk("bne_resume", 64'(valid_EX), 64'd1);
      end

      cycle(1'b1, 1'b1, I_MULT, 1'b0);
      stalls = 0; ncyc = 0;
      while (!(valid_EX && regsel_EX == 2'd2) && ncyc < 12) begin
         cycle(1'b1, 1'b1, I_MFLO, 1'b0);
         ncyc++;
         if (!s_rdy) stalls++;
      end
      chk("mflo_stalls", 64'(stalls), 64'd3);
      chk("mflo_latency", 64'(ncyc), 64'd4);
      cycle(1'b1, 1'b1, I_MULT, 1'b0);
      cycle(1'b1, 1'b1, I_ADD, 1'b0);
      chk("mult_add_nostall", 64'(s_rdy), 64'd1);
      chk("mult_add_op", 64'(alu_op_EX), 64'd4);
      repeat (MULT_CYCLES) cycle(1'b1, 1'b0, 32'h0, 1'b0);

      cycle(1'b1, 1'b1, I_BNE, 1'b0);
      cycle(1'b0, 1'b1, I_ADD, 1'b0);
      chk("rst_branch_pc", 64'(pc_src_EX), 64'd0);
      cycle(1'b1, 1'b1, I_ADD, 1'b0);
      chk("rst_branch_rdy", 64'(s_rdy), 64'd1);

      for (int n = 0; n < 3000; n++)
         cycle(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
